// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, register-file addressing,
// ABI register indices and the ALU control codes.
package core_pkg;

    localparam int size   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef logic [size-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    // x0 is hardwired to zero; ra and sp follow the standard ABI numbering.
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;

    // ALU control codes driven by the decoder.
    typedef enum logic [3:0] {
        ADD  = 4'b0000,
        SUB  = 4'b0111,
        SLT  = 4'b0100,
        SLTU = 4'b1100,
        AND  = 4'b0010,
        OR   = 4'b0001,
        XOR  = 4'b1001,
        SLL  = 4'b1000,
        SRL  = 4'b1010,
        SRA  = 4'b1110,
        BGE  = 4'b1011,
        BNE  = 4'b1111
    } alu_op_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports and one write port.
// The decode/write-back side is the master, the register file the slave.
interface reg_file_if #(
    parameter int size = 32,
    parameter int NREG = 32
);
    import core_pkg::*;

    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   RA1;
    logic [AW-1:0]   RA2;
    logic [AW-1:0]   WA;
    logic [size-1:0] WD;
    logic            WE;
    logic [size-1:0] RD1;
    logic [size-1:0] RD2;

    modport master (
        output RA1, RA2, WA, WD, WE,
        input  RD1, RD2
    );

    modport slave (
        input  RA1, RA2, WA, WD, WE,
        output RD1, RD2
    );

endinterface

// File: rtl/reg_file.sv
// Integer register file: NREG registers of size bits, x0 hardwired to zero,
// one synchronous write port, two combinational read ports with an optional
// same-cycle write-to-read bypass.
module reg_file #(
    parameter int size   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic      CLK,
    input  logic      RESET,
    reg_file_if.slave bus
);
    import core_pkg::*;

    localparam int AW = $clog2(NREG);

    // x0 has no storage behind it.
    logic [size-1:0] regs [1:NREG-1];
    logic [size-1:0] stored1;
    logic [size-1:0] stored2;

    // Resolve one read port: x0, then bypass of this cycle's write, then storage.
    function automatic logic [size-1:0] read_sel(
        input logic [AW-1:0]   ra,
        input logic [size-1:0] stored,
        input logic            we,
        input logic            rst,
        input logic [AW-1:0]   wa,
        input logic [size-1:0] wd
    );
        if (ra == AW'(REG_ZERO))
            return '0;
        if ((BYPASS != 0) && we && !rst && (wa == ra))
            return wd;
        return stored;
    endfunction

    // Write port: synchronous clear has priority, writes to x0 are dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the whole array is cleared because reads after reset must
            // return 0; a storage array that only needs defined data after a
            // write would be left unreset so it can map onto RAM.
            for (int i = 1; i < NREG; i++)
                regs[i] <= '0;
        end else if (bus.WE && (bus.WA != AW'(REG_ZERO))) begin
            // NOTE: state is updated with non-blocking assignments so every
            // reader in this clock edge sees the pre-edge value.
            regs[bus.WA] <= bus.WD;
        end
    end

    // Fetch stored contents for both read addresses; x0 never indexes the array.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        stored1 = '0;
        stored2 = '0;
        if (bus.RA1 != AW'(REG_ZERO))
            stored1 = regs[bus.RA1];
        if (bus.RA2 != AW'(REG_ZERO))
            stored2 = regs[bus.RA2];
    end

    assign bus.RD1 = read_sel(bus.RA1, stored1, bus.WE, RESET, bus.WA, bus.WD);
    assign bus.RD2 = read_sel(bus.RA2, stored2, bus.WE, RESET, bus.WA, bus.WD);

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: one instance with bypass, one without,
// both driven identically and compared against a behavioural array model.
module tb_reg_file;
    import core_pkg::*;

    logic clk;
    logic rst;

    reg_file_if #(.size(32), .NREG(32)) bus_b ();
    reg_file_if #(.size(32), .NREG(32)) bus_n ();

    reg_file #(.size(32), .NREG(32), .BYPASS(1)) dut_b (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_b)
    );

    reg_file #(.size(32), .NREG(32), .BYPASS(0)) dut_n (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state and the inputs currently applied.
    word_t     model [32];
    reg_addr_t cur_ra1, cur_ra2, cur_wa;
    word_t     cur_wd;
    logic      cur_we, cur_rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic word_t alu_ref(input alu_op_t op, input word_t a, input word_t b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Expected read value straight from the read rules.
    function automatic word_t exp_rd(input bit bypass, input reg_addr_t ra);
        if (ra == 0) return '0;
        if (bypass && cur_we && !cur_rst && cur_wa == ra) return cur_wd;
        return model[ra];
    endfunction

    task automatic drive(input logic r, input reg_addr_t ra1, input reg_addr_t ra2,
                         input logic we, input reg_addr_t wa, input word_t wd);
        cur_rst = r;  cur_ra1 = ra1; cur_ra2 = ra2;
        cur_we  = we; cur_wa  = wa;  cur_wd  = wd;
        rst = r;
        bus_b.RA1 = ra1; bus_b.RA2 = ra2; bus_b.WE = we; bus_b.WA = wa; bus_b.WD = wd;
        bus_n.RA1 = ra1; bus_n.RA2 = ra2; bus_n.WE = we; bus_n.WA = wa; bus_n.WD = wd;
        #1;
    endtask

    // Advance one clock edge, apply the write rules to the model, settle at negedge.
    task automatic tick();
        @(posedge clk);
        if (cur_rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (cur_we && cur_wa != 0) begin
            model[cur_wa] = cur_wd;
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_b_rd1"}, bus_b.RD1, exp_rd(1'b1, cur_ra1));
        check({tag, "_b_rd2"}, bus_b.RD2, exp_rd(1'b1, cur_ra2));
        check({tag, "_n_rd1"}, bus_n.RD1, exp_rd(1'b0, cur_ra1));
        check({tag, "_n_rd2"}, bus_n.RD2, exp_rd(1'b0, cur_ra2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t alu_out;

        // Reset for two edges, then every address reads zero.
        drive(1'b1, 0, 0, 1'b0, 0, '0);
        tick();
        tick();
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, reg_addr_t'(a), reg_addr_t'(31 - a), 1'b0, 0, '0);
            check("rst_sweep_b_rd1", bus_b.RD1, 32'd0);
            check("rst_sweep_b_rd2", bus_b.RD2, 32'd0);
            check("rst_sweep_n_rd1", bus_n.RD1, 32'd0);
            check("rst_sweep_n_rd2", bus_n.RD2, 32'd0);
        end

        // Basic write/read, including a negative value.
        drive(1'b0, 0, 0, 1'b1, 5, 32'd21);
        tick();
        drive(1'b0, 5, 6, 1'b0, 0, '0);
        check("basic_rd1", bus_b.RD1, 32'd21);
        check("basic_rd2", bus_b.RD2, 32'd0);
        check_all("basic");
        drive(1'b0, 0, 0, 1'b1, 6, 32'hFFFF_FFF8);
        tick();
        drive(1'b0, 5, 6, 1'b0, 0, '0);
        check("neg_rd2", bus_b.RD2, 32'hFFFF_FFF8);
        check_all("neg");

        // x0 ignores writes and always reads zero.
        drive(1'b0, 0, 0, 1'b1, 0, 32'hDEAD_BEEF);
        check("x0_same_b", bus_b.RD1, 32'd0);
        check("x0_same_n", bus_n.RD1, 32'd0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 0, '0);
        check("x0_next_b", bus_b.RD1, 32'd0);
        check_all("x0_next");

        // Bypass versus no bypass on a same-cycle write to the read address.
        drive(1'b0, 0, 0, 1'b1, 7, 32'd3);
        tick();
        drive(1'b0, 7, 7, 1'b1, 7, 32'd19);
        check("byp_b_rd1", bus_b.RD1, 32'd19);
        check("byp_b_rd2", bus_b.RD2, 32'd19);
        check("byp_n_rd1", bus_n.RD1, 32'd3);
        check("byp_n_rd2", bus_n.RD2, 32'd3);
        tick();
        drive(1'b0, 7, 7, 1'b0, 0, '0);
        check("byp_next_b", bus_b.RD1, 32'd19);
        check("byp_next_n", bus_n.RD1, 32'd19);

        // Write in the reset cycle is discarded and bypass is suppressed.
        drive(1'b0, 0, 0, 1'b1, 9, 32'd15);
        tick();
        drive(1'b1, 9, 9, 1'b1, 9, 32'd9);
        check("rstwr_during_b", bus_b.RD1, 32'd15);
        check("rstwr_during_n", bus_n.RD1, 32'd15);
        tick();
        drive(1'b0, 9, 7, 1'b0, 0, '0);
        check("rstwr_after_b", bus_b.RD1, 32'd0);
        check("rstwr_after_n", bus_n.RD1, 32'd0);
        check("rstwr_other_b", bus_b.RD2, 32'd0);

        // ALU link: x3 = x1 - x2 via the read ports and write-back.
        drive(1'b0, 0, 0, 1'b1, REG_RA, 32'd22);
        tick();
        drive(1'b0, 0, 0, 1'b1, REG_SP, 32'd5);
        tick();
        drive(1'b0, REG_RA, REG_SP, 1'b0, 0, '0);
        check("alu_x", bus_b.RD1, 32'd22);
        check("alu_y", bus_b.RD2, 32'd5);
        alu_out = alu_ref(SUB, bus_b.RD1, bus_b.RD2);
        drive(1'b0, REG_RA, REG_SP, 1'b1, 3, alu_out);
        tick();
        drive(1'b0, 3, 3, 1'b0, 0, '0);
        check("alu_wb_b", bus_b.RD1, 32'd17);
        check("alu_wb_n", bus_n.RD2, 32'd17);

        // Randomized traffic against the model, occasional resets.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0),
                  reg_addr_t'($urandom_range(0, 31)),
                  reg_addr_t'($urandom_range(0, 31)),
                  $urandom_range(0, 1) == 1,
                  reg_addr_t'($urandom_range(0, 31)),
                  word_t'($urandom));
            check_all("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file of the single-cycle RISC-V-style core, directly upstream of the ALU.
- Its two read ports drive the ALU operands X and Y, through the operand/immediate mux for Y.
- Its write port takes the write-back value, which is either the ALU RESULT or the load data.
- 32 architectural registers; x0 reads as zero and ignores writes.
- Optional same-cycle write-to-read bypass, so a value written this cycle appears on the read ports immediately.

Parameters:
- size, 32, data width in bits (matches ALU `size`).
- NREG, 32, number of registers; must be a power of two, at least 2.
- BYPASS, 1, 1 = read ports forward WD on a same-cycle write to the addressed register; 0 = read ports show the stored value only.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RA1  in  $clog2(NREG)  read address, port 1 (rs1).
- RA2  in  $clog2(NREG)  read address, port 2 (rs2).
- WA  in  $clog2(NREG)  write address (rd).
- WD  in  size  write data (write-back value).
- WE  in  1  write enable.
- RD1  out  size  read data, port 1 (goes to ALU X).
- RD2  out  size  read data, port 2 (goes to operand mux, then ALU Y).

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET. There is no asynchronous path.
- Storage: array regs[1..NREG-1] of size bits. x0 is not stored.
- Write:
  - At posedge CLK, if RESET=1, every regs[i] becomes 0. RESET has priority over WE.
  - Otherwise, if WE=1 and WA≠0, regs[WA] takes WD.
  - Otherwise no state change.
- Write latency: one cycle. The stored value is visible on the read ports from the cycle after the edge.
- Reads are combinational, zero latency. For each port p, in priority order:
  - RAp=0 gives RDp=0, including when WE=1 and WA=0.
  - BYPASS=1, WE=1, RESET=0 and WA=RAp gives RDp=WD.
  - Otherwise RDp=regs[RAp].
- Bypass and reset: bypass is suppressed while RESET=1, so RDp shows the stored contents. After the reset edge all reads return 0.
- Power-up: register contents are undefined until the first reset edge. The bench must apply RESET for at least one edge.
- Shared address: RA1=RA2 is legal; both ports return identical data.
- Width rules:
  - No sign handling; data is stored bit-exact, so negative values survive.
  - Addresses are exactly $clog2(NREG) bits, so no out-of-range check is needed.
- Reset mid-operation: a write attempted in the same cycle as RESET=1 is discarded, and that register reads 0 afterwards.
- State machine: none beyond the register array. No stall input; the upstream control holds WE=0 when no write is wanted.

Decomposition:
- Package core_pkg:
  - parameter size=32 and NREG=32.
  - localparam REG_AW=$clog2(NREG).
  - typedef word_t (logic [size-1:0]) and typedef reg_addr_t (logic [REG_AW-1:0]).
  - constant REG_ZERO=0.
  - ABI index constants: REG_RA=1, REG_SP=2.
- The ALU control codes already in use also move into core_pkg as an enum alu_op_t. Values: ADD=4'b0000, SUB=4'b0111, SLT=4'b0100, SLTU=4'b1100, AND=4'b0010, OR=4'b0001, XOR=4'b1001, SLL=4'b1000, SRL=4'b1010, SRA=4'b1110, BGE=4'b1011, BNE=4'b1111.
- Sub-module: none. The read logic is one small function shared by both ports, which keeps the block flat.

Test Plan:
- Reset: RESET=1 for 2 edges, then RESET=0 and sweep RA1/RA2 over 0..31 → every RD1 and RD2 = 0.
- Basic write/read: WE=1, WA=5, WD=21; next cycle WE=0, RA1=5, RA2=6 → RD1=21, RD2=0. Then WA=6, WD=32'hFFFFFFF8 (−8); next cycle RA2=6 → RD2=32'hFFFFFFF8.
- x0 hardwire: WE=1, WA=0, WD=32'hDEADBEEF; same cycle and next cycle RA1=0 → RD1=0 both times.
- Bypass: BYPASS=1, regs[7]=3, then WE=1, WA=7, WD=19, RA1=7, RA2=7 in one cycle → RD1=RD2=19 in that cycle, and RD1=19 next cycle with WE=0. Rerun with BYPASS=0 → RD1=RD2=3 in the write cycle, 19 the cycle after.
- Reset mid-write: regs[9]=15, then RESET=1, WE=1, WA=9, WD=9 in one cycle → RD1 (RA1=9) shows 15 during that cycle and 0 after the edge, never 9.
- ALU link: write x1=22 and x2=5; RA1=1 and RA2=2 drive the ALU with CONTROL=4'b0111 → RESULT=17. Write RESULT back to x3, then read x3 → 17.
